// File: rtl/riscv_branch_predictor.sv
// -----------------------------------------------------------------------------
// riscv_branch_predictor
//
// Fetch-side branch predictor. Resolved branch records from execute train a
// direct-mapped BTB, a table of 2-bit saturating direction counters (BHT) and
// a return address stack (RAS). Every cycle the current fetch PC is looked up
// combinationally against the registered state to produce a taken/target
// prediction for next-PC selection.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   fetch_valid_i         fetch_pc_i is valid this cycle
//   fetch_pc_i[31:0]      PC being fetched (word aligned)
//   predict_taken_o       predicted redirect
//   predict_target_o      predicted next PC (fetch_pc_i+4 when not taken)
//   branch_request_i      execute resolved a branch/jump this cycle
//   branch_is_taken_i     resolved direction
//   branch_is_call_i      resolved instruction is a call
//   branch_is_ret_i       resolved instruction is a return
//   branch_is_jmp_i       unconditional jump (JAL/JALR)
//   branch_source_i[31:0] PC of the resolved instruction
//   branch_target_i[31:0] resolved target
//
// Handshake: there is no back-pressure. A training record is consumed on
// every rising edge where branch_request_i=1, and a prediction is presented
// in the same cycle fetch_valid_i=1; neither side can stall the other.
// -----------------------------------------------------------------------------
module riscv_branch_predictor #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int BTB_IDX_W       = 5,
  parameter int NUM_BHT_ENTRIES = 256,
  parameter int BHT_IDX_W       = 8,
  parameter int NUM_RAS_ENTRIES = 8,
  parameter int RAS_IDX_W       = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_pc_i,
  output logic        predict_taken_o,
  output logic [31:0] predict_target_o,
  input  logic        branch_request_i,
  input  logic        branch_is_taken_i,
  input  logic        branch_is_call_i,
  input  logic        branch_is_ret_i,
  input  logic        branch_is_jmp_i,
  input  logic [31:0] branch_source_i,
  input  logic [31:0] branch_target_i
);

  localparam int TAG_W = 32 - BTB_IDX_W - 2;
  localparam logic [RAS_IDX_W:0] RAS_FULL = (RAS_IDX_W + 1)'(NUM_RAS_ENTRIES);

  // BTB storage
  logic               r_btb_valid   [NUM_BTB_ENTRIES];
  logic [TAG_W-1:0]   r_btb_tag     [NUM_BTB_ENTRIES];
  logic [31:0]        r_btb_target  [NUM_BTB_ENTRIES];
  logic               r_btb_is_call [NUM_BTB_ENTRIES];
  logic               r_btb_is_ret  [NUM_BTB_ENTRIES];
  logic               r_btb_is_jmp  [NUM_BTB_ENTRIES];

  // BHT storage
  logic [1:0]         r_bht [NUM_BHT_ENTRIES];

  // RAS storage: r_ras_ptr is the next free slot, the top is r_ras_ptr-1.
  logic [31:0]        r_ras [NUM_RAS_ENTRIES];
  logic [RAS_IDX_W-1:0] r_ras_ptr;
  logic [RAS_IDX_W:0]   r_ras_cnt;

  // Lookup side
  logic [BTB_IDX_W-1:0] w_f_btb_idx;
  logic [TAG_W-1:0]     w_f_tag;
  logic [BHT_IDX_W-1:0] w_f_bht_idx;
  logic                 w_f_hit;
  logic [31:0]          w_f_pc_plus4;
  logic [RAS_IDX_W-1:0] w_ras_top_idx;
  logic [31:0]          w_ras_top;

  // Update side
  logic [BTB_IDX_W-1:0] w_u_btb_idx;
  logic [TAG_W-1:0]     w_u_tag;
  logic [BHT_IDX_W-1:0] w_u_bht_idx;
  logic [1:0]           w_u_bht_cur;

  assign w_f_btb_idx   = fetch_pc_i[BTB_IDX_W+1:2];
  assign w_f_tag       = fetch_pc_i[31:BTB_IDX_W+2];
  assign w_f_bht_idx   = fetch_pc_i[BHT_IDX_W+1:2];
  assign w_f_hit       = r_btb_valid[w_f_btb_idx] && (r_btb_tag[w_f_btb_idx] == w_f_tag);
  assign w_f_pc_plus4  = fetch_pc_i + 32'd4;
  assign w_ras_top_idx = r_ras_ptr - {{(RAS_IDX_W-1){1'b0}}, 1'b1};
  assign w_ras_top     = r_ras[w_ras_top_idx];

  assign w_u_btb_idx   = branch_source_i[BTB_IDX_W+1:2];
  assign w_u_tag       = branch_source_i[31:BTB_IDX_W+2];
  assign w_u_bht_idx   = branch_source_i[BHT_IDX_W+1:2];
  assign w_u_bht_cur   = r_bht[w_u_bht_idx];

  // Prediction: returns use the RAS when it holds anything, otherwise fall
  // back to the last target seen in the BTB. Calls/jumps are always taken;
  // conditionals follow the counter MSB.
  always_comb begin
    predict_taken_o  = 1'b0;
    predict_target_o = w_f_pc_plus4;
    if (fetch_valid_i && w_f_hit) begin
      if (r_btb_is_ret[w_f_btb_idx]) begin
        predict_taken_o  = 1'b1;
        predict_target_o = (r_ras_cnt != '0) ? w_ras_top : r_btb_target[w_f_btb_idx];
      end else if (r_btb_is_call[w_f_btb_idx] || r_btb_is_jmp[w_f_btb_idx]) begin
        predict_taken_o  = 1'b1;
        predict_target_o = r_btb_target[w_f_btb_idx];
      end else if (r_bht[w_f_bht_idx][1]) begin
        predict_taken_o  = 1'b1;
        predict_target_o = r_btb_target[w_f_btb_idx];
      end
    end
  end

  // BTB: only taken outcomes allocate; an aliasing entry is simply replaced.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
        r_btb_valid[i] <= 1'b0;
      end
    end else if (branch_request_i && branch_is_taken_i) begin
      r_btb_valid[w_u_btb_idx]   <= 1'b1;
      r_btb_tag[w_u_btb_idx]     <= w_u_tag;
      r_btb_target[w_u_btb_idx]  <= branch_target_i;
      r_btb_is_call[w_u_btb_idx] <= branch_is_call_i;
      r_btb_is_ret[w_u_btb_idx]  <= branch_is_ret_i;
      r_btb_is_jmp[w_u_btb_idx]  <= branch_is_jmp_i;
    end
  end

  // BHT: saturating 2-bit counters, weakly not-taken out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BHT_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (branch_request_i) begin
      if (branch_is_taken_i) begin
        if (w_u_bht_cur != 2'b11) r_bht[w_u_bht_idx] <= w_u_bht_cur + 2'b01;
      end else begin
        if (w_u_bht_cur != 2'b00) r_bht[w_u_bht_idx] <= w_u_bht_cur - 2'b01;
      end
    end
  end

  // RAS pointer/count. A push on a full stack wraps and overwrites the oldest
  // entry while the count saturates. Call wins when call and ret coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (branch_request_i) begin
      if (branch_is_call_i) begin
        r_ras_ptr <= r_ras_ptr + {{(RAS_IDX_W-1){1'b0}}, 1'b1};
        if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + {{RAS_IDX_W{1'b0}}, 1'b1};
      end else if (branch_is_ret_i && (r_ras_cnt != '0)) begin
        r_ras_ptr <= w_ras_top_idx;
        r_ras_cnt <= r_ras_cnt - {{RAS_IDX_W{1'b0}}, 1'b1};
      end
    end
  end

  // RAS data needs no reset: a zero count masks stale contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && branch_request_i && branch_is_call_i) begin
      r_ras[r_ras_ptr] <= branch_source_i + 32'd4;
    end
  end

endmodule

// File: tb/tb_riscv_branch_predictor.sv
module tb_riscv_branch_predictor;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        br_req;
  logic        br_taken;
  logic        br_call;
  logic        br_ret;
  logic        br_jmp;
  logic [31:0] br_src;
  logic [31:0] br_tgt;

  logic [32:0] exp_q[$];
  logic [32:0] got;
  logic [32:0] exp;
  int          n_tests;
  int          n_fail;

  riscv_branch_predictor dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .fetch_valid_i     (fetch_valid),
    .fetch_pc_i        (fetch_pc),
    .predict_taken_o   (predict_taken),
    .predict_target_o  (predict_target),
    .branch_request_i  (br_req),
    .branch_is_taken_i (br_taken),
    .branch_is_call_i  (br_call),
    .branch_is_ret_i   (br_ret),
    .branch_is_jmp_i   (br_jmp),
    .branch_source_i   (br_src),
    .branch_target_i   (br_tgt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: all start and end just after a falling edge
  task automatic clear_branch();
    br_req = 1'b0; br_taken = 1'b0; br_call = 1'b0; br_ret = 1'b0; br_jmp = 1'b0;
    br_src = '0;   br_tgt = '0;
  endtask

  task automatic drive_branch(input logic [31:0] src, input logic [31:0] tgt,
                              input logic tk, input logic cl, input logic rt, input logic jp);
    br_req = 1'b1; br_src = src; br_tgt = tgt;
    br_taken = tk; br_call = cl; br_ret = rt; br_jmp = jp;
  endtask

  task automatic resolve(input logic [31:0] src, input logic [31:0] tgt,
                         input logic tk, input logic cl, input logic rt, input logic jp);
    drive_branch(src, tgt, tk, cl, rt, jp);
    @(negedge clk);
    clear_branch();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_branch();
    fetch_valid = 1'b0;
    fetch_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // drive a fetch and record what the prediction must be
  task automatic drive_fetch(input logic valid, input logic [31:0] pc,
                             input logic exp_taken, input logic [31:0] exp_target);
    fetch_valid = valid;
    fetch_pc = pc;
    exp_q.push_back({exp_taken, exp_target});
  endtask

  task automatic test_reset();
    do_reset();
    drive_fetch(1'b1, 32'h100, 1'b0, 32'h104);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_fetch: got %h exp %h", got, exp); end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] pc;
      pc = 32'($urandom_range(0, 32'h3FFF_FFFF)) << 2;
      drive_fetch(1'b1, pc, 1'b0, pc + 32'd4);
      #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_rand_fetch: pc %h got %h exp %h", pc, got, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_conditional();
    // counter 01 -> 10 after one taken: predicts taken only if reset value is 01
    resolve(32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_fetch(1'b1, 32'h200, 1'b1, 32'h180);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL cond_taken: got %h exp %h", got, exp); end
    // fetch_valid low suppresses the prediction
    drive_fetch(1'b0, 32'h200, 1'b0, 32'h204);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got[32] !== exp[32]) begin n_fail++; $display("FAIL fetch_invalid: got %b exp %b", got[32], exp[32]); end
    resolve(32'h200, 32'h180, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_fetch(1'b1, 32'h200, 1'b0, 32'h204);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL cond_bht01: got %h exp %h", got, exp); end
    resolve(32'h200, 32'h180, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_fetch(1'b1, 32'h200, 1'b0, 32'h204);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL cond_bht00: got %h exp %h", got, exp); end
    // saturation at 00: one taken gives 01, still not taken
    resolve(32'h200, 32'h180, 1'b0, 1'b0, 1'b0, 1'b0);
    resolve(32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_fetch(1'b1, 32'h200, 1'b0, 32'h204);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL cond_sat_low: got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_call_ret();
    resolve(32'h300, 32'h800, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_fetch(1'b1, 32'h300, 1'b1, 32'h800);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL call_hit: got %h exp %h", got, exp); end
    resolve(32'h900, 32'h304, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_fetch(1'b1, 32'h900, 1'b1, 32'h304);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ret_empty_btb: got %h exp %h", got, exp); end
    // new call pushes 0x508; return now comes from the RAS, not the BTB
    resolve(32'h504, 32'hA00, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_fetch(1'b1, 32'h900, 1'b1, 32'h508);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ret_from_ras: got %h exp %h", got, exp); end
    resolve(32'h900, 32'h508, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_fetch(1'b1, 32'h900, 1'b1, 32'h508);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ret_after_pop: got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_ras_overflow();
    // return site at 0x2008 (BTB index 2) trained while the stack is empty
    resolve(32'h2008, 32'hDEAD0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      resolve(32'h1000 + 32'(16 * k), 32'h4000, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    for (int j = 0; j < 8; j++) begin
      drive_fetch(1'b1, 32'h2008, 1'b1, 32'h1084 - 32'(16 * j));
      #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL ras_pop_%0d: got %h exp %h", j, got, exp); end
      resolve(32'h2008, 32'hDEAD0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    drive_fetch(1'b1, 32'h2008, 1'b1, 32'hDEAD0);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ras_drained: got %h exp %h", got, exp); end
    resolve(32'h2008, 32'hDEAD0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_fetch(1'b1, 32'h2008, 1'b1, 32'hDEAD0);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ras_underflow: got %h exp %h", got, exp); end
    // count must still be 0: one push then one pop empties it again
    resolve(32'h3000, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_fetch(1'b1, 32'h2008, 1'b1, 32'h3004);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ras_push_after_underflow: got %h exp %h", got, exp); end
    resolve(32'h2008, 32'hDEAD0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_fetch(1'b1, 32'h2008, 1'b1, 32'hDEAD0);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ras_empty_again: got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    // lookup and update in the same cycle: lookup sees old state
    drive_branch(32'h200, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_fetch(1'b1, 32'h200, 1'b0, 32'h204);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL same_cycle_old: got %h exp %h", got, exp); end
    @(negedge clk);
    clear_branch();
    drive_fetch(1'b1, 32'h200, 1'b1, 32'h180);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL same_cycle_next: got %h exp %h", got, exp); end
    // leave a call on the RAS, then reset with a simultaneous update
    resolve(32'h600, 32'h900, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive_branch(32'h400, 32'h700, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    clear_branch();
    drive_fetch(1'b1, 32'h400, 1'b0, 32'h404);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_blocks_update: got %h exp %h", got, exp); end
    drive_fetch(1'b1, 32'h200, 1'b0, 32'h204);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_clears_btb: got %h exp %h", got, exp); end
    // RAS count was cleared: a return resolves to its BTB target
    resolve(32'h2008, 32'hDEAD0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_fetch(1'b1, 32'h2008, 1'b1, 32'hDEAD0);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_clears_ras: got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_alias();
    do_reset();
    resolve(32'h200, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    resolve(32'h280, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_fetch(1'b1, 32'h200, 1'b0, 32'h204);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL alias_miss: got %h exp %h", got, exp); end
    drive_fetch(1'b1, 32'h280, 1'b1, 32'h80);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL alias_new_hit: got %h exp %h", got, exp); end
    // wrap of the target adder at the top of the address space
    drive_fetch(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    #1 got = {predict_taken, predict_target}; exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pc_wrap: got %h exp %h", got, exp); end
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    clear_branch();
    fetch_valid = 1'b0;
    fetch_pc = '0;
    @(negedge clk);
    test_reset();
    test_conditional();
    test_call_ret();
    test_ras_overflow();
    test_back_to_back();
    test_alias();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
